day2_puzzle: RTL and testbench

Hardware solver for the day-2 "invalid product ID" puzzle. It holds NUM_UNITS decimal ID ranges and scans all of them in parallel, one ID per unit per cycle. Each unit sums the IDs whose decimal digit string is a repetition of a shorter digit block. A registered adder chain reduces the per-unit sums into one total, exposed as id_sum.

---
 rtl/day2_pkg.sv | 13 +
 rtl/day2_puzzle_if.sv | 15 +
 rtl/day2_range_unit.sv | 105 ++++++++++
 rtl/day2_puzzle.sv | 53 +++++
 tb/tb_day2_puzzle.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/day2_pkg.sv
// Shared types and helpers for the day-2 invalid-ID solver.
package day2_pkg;

  // Decimal digits needed to hold any W-bit value: ceil(W * log10(2)).
  function automatic int digit_cap(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, SCAN, DONE} unit_state_e;

  typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/day2_puzzle_if.sv
// Range load / result bus between the solver and whoever drives it.
interface day2_puzzle_if #(
  parameter int W         = 48,
  parameter int NUM_UNITS = 38
);
  logic                        load;
  logic                        en;
  logic [NUM_UNITS-1:0][W-1:0] start_id;
  logic [NUM_UNITS-1:0][W-1:0] end_id;
  logic [W-1:0]                id_sum;
  logic                        done;

  modport master (output load, en, start_id, end_id, input id_sum, done);
  modport slave  (input load, en, start_id, end_id, output id_sum, done);
endinterface

// File: rtl/day2_range_unit.sv
// One range: binary->BCD conversion of the start, then a lockstep binary/BCD
// scan that accumulates every ID whose digits repeat a shorter block.
module day2_range_unit import day2_pkg::*; #(
  parameter int W      = 48,
  parameter int PUZZLE = 1,
  parameter int D      = digit_cap(W)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_en,
  input  logic [W-1:0] i_start,
  input  logic [W-1:0] i_end,
  output logic [W-1:0] o_sum,
  output logic         o_done
);
  localparam int             CW   = $clog2(W);
  localparam logic [4*D-1:0] ONES = '1;

  unit_state_e          r_state;
  logic [W-1:0]         r_cur, r_end, r_shift, r_sum;
  logic [CW-1:0]        r_cnt;
  bcd_digit_t [D-1:0]   r_bcd;
  bcd_digit_t [D-1:0]   w_adj, w_inc;
  logic [4*D-1:0]       w_flat;
  int                   w_n;
  logic                 w_invalid;

  assign w_flat = r_bcd;

  // Double-dabble correction applied before each shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < D; i++)
      if (r_bcd[i] >= 4'd5) w_adj[i] = r_bcd[i] + 4'd3;
  end

  always_comb begin
    logic c;
    c     = 1'b1;
    w_inc = r_bcd;
    for (int i = 0; i < D; i++) begin
      if (c) begin
        if (r_bcd[i] == 4'd9) w_inc[i] = 4'd0;
        else begin
          w_inc[i] = r_bcd[i] + 4'd1;
          c        = 1'b0;
        end
      end
    end
  end

  // A block of d digits repeats across n digits iff the number shifted down by
  // d digits equals its own low n-d digits (digits above n are already zero).
  always_comb begin
    w_n = 0;
    for (int i = 0; i < D; i++)
      if (r_bcd[i] != 4'd0) w_n = i + 1;
    w_invalid = 1'b0;
    for (int n = 2; n <= D; n++)
      for (int d = 1; d < n; d++)
        if ((n % d == 0) && (PUZZLE == 2 || 2 * d == n) && (w_n == n) &&
            ((w_flat >> (4 * d)) == (w_flat & (ONES >> (4 * (D - n + d))))))
          w_invalid = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cur   <= '0;
      r_end   <= '0;
      r_shift <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
    end else if (i_load) begin
      r_state <= CONV;
      r_cur   <= i_start;
      r_end   <= i_end;
      r_shift <= i_start;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
    end else if (i_en) begin
      case (r_state)
        CONV: begin
          {r_bcd, r_shift} <= {w_adj, r_shift} << 1;
          r_cnt            <= r_cnt + CW'(1);
          if (r_cnt == CW'(W - 1)) r_state <= (r_cur > r_end) ? DONE : SCAN;
        end
        SCAN: begin
          if (w_invalid) r_sum <= r_sum + r_cur;
          r_cur <= r_cur + W'(1);
          r_bcd <= w_inc;
          if (r_cur == r_end) r_state <= DONE;
        end
        default: ;
      endcase
    end
  end

  assign o_sum  = r_sum;
  assign o_done = (r_state == DONE) || (r_state == IDLE);

endmodule

// File: rtl/day2_puzzle.sv
// Top: NUM_UNITS range units, a pairwise registered reduction chain and the
// global done flag.
module day2_puzzle import day2_pkg::*; #(
  parameter int W         = 48,
  parameter int NUM_UNITS = 38,
  parameter int PUZZLE    = 1
) (
  input  logic       clock,
  input  logic       reset,
  day2_puzzle_if.slave bus
);
  localparam int S = (NUM_UNITS + 1) / 2;

  logic [W-1:0]         w_pair [2*S];
  logic [NUM_UNITS-1:0] w_udone;
  logic [S-1:0][W-1:0]  r_acc;
  logic                 r_done;

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
    day2_range_unit #(.W(W), .PUZZLE(PUZZLE)) u_unit (
      .i_clk   (clock),
      .i_rst_n (reset),
      .i_load  (bus.load),
      .i_en    (bus.en),
      .i_start (bus.start_id[u]),
      .i_end   (bus.end_id[u]),
      .o_sum   (w_pair[u]),
      .o_done  (w_udone[u])
    );
  end

  if (2 * S > NUM_UNITS) begin : g_pad
    assign w_pair[2*S-1] = '0;
  end

  // Stage k folds pair k into the running total; it settles S cycles after
  // the unit sums stop changing.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_acc  <= '0;
      r_done <= 1'b0;
    end else begin
      r_acc[0] <= w_pair[0] + w_pair[1];
      for (int k = 1; k < S; k++)
        r_acc[k] <= r_acc[k-1] + w_pair[2*k] + w_pair[2*k+1];
      r_done <= bus.load ? 1'b0 : &w_udone;
    end
  end

  assign bus.id_sum = r_acc[S-1];
  assign bus.done   = r_done;

endmodule

// File: tb/tb_day2_puzzle.sv
// Bench for day2_puzzle: two instances (both puzzle rules) fed identical ranges,
// checked every cycle against a string-based model of the repeat rules.
module tb_day2_puzzle;
  localparam int W = 48;
  localparam int N = 38;
  localparam int S = (N + 1) / 2;
  localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  day2_puzzle_if #(.W(W), .NUM_UNITS(N)) ifa (), ifb ();

  day2_puzzle #(.W(W), .NUM_UNITS(N), .PUZZLE(1)) dut1 (.clock(clock), .reset(reset), .bus(ifa));
  day2_puzzle #(.W(W), .NUM_UNITS(N), .PUZZLE(2)) dut2 (.clock(clock), .reset(reset), .bus(ifb));

  int n_tests = 0;
  int n_fail  = 0;

  longint unsigned r_s [N];
  longint unsigned r_e [N];

  // model state
  bit              m_valid = 1'b0;
  bit              m_rst, m_done;
  int              m_en_cnt, m_need, m_done_cnt;
  longint unsigned m_tgt1, m_tgt2;
  int              pend_need;
  longint unsigned pend_t1, pend_t2;

  longint unsigned ex_s [11] = '{11, 95, 998, 1188511880, 222220, 1698522, 446443,
                                 38593856, 565653, 824824821, 2121212118};
  longint unsigned ex_e [11] = '{22, 115, 1012, 1188511890, 222224, 1698528, 446449,
                                 38593862, 565659, 824824827, 2121212124};

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_invalid(input longint unsigned v, input int p);
    string s, blk, t;
    int    n;
    if (v == 0) return 1'b0;
    s = $sformatf("%0d", v);
    n = s.len();
    for (int d = 1; d < n; d++) begin
      if (n % d != 0) continue;
      if (p == 1 && 2 * d != n) continue;
      blk = s.substr(0, d - 1);
      t   = "";
      for (int r = 0; r < n / d; r++) t = {t, blk};
      if (t == s) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic longint unsigned range_sum(input longint unsigned s, input longint unsigned e,
                                                input int p);
    longint unsigned acc = 0;
    for (longint unsigned v = s; v <= e; v++)
      if (is_invalid(v, p)) acc += v;
    return acc & MASK;
  endfunction

  task automatic apply_ranges();
    int mx = 0;
    pend_t1 = 0;
    pend_t2 = 0;
    for (int i = 0; i < N; i++) begin
      ifa.start_id[i] = r_s[i][W-1:0];
      ifa.end_id[i]   = r_e[i][W-1:0];
      ifb.start_id[i] = r_s[i][W-1:0];
      ifb.end_id[i]   = r_e[i][W-1:0];
      pend_t1 = (pend_t1 + range_sum(r_s[i], r_e[i], 1)) & MASK;
      pend_t2 = (pend_t2 + range_sum(r_s[i], r_e[i], 2)) & MASK;
      if (r_s[i] <= r_e[i] && int'(r_e[i] - r_s[i] + 1) > mx) mx = int'(r_e[i] - r_s[i] + 1);
    end
    pend_need = W + mx;
  endtask

  // One clock: drive, take the edge, advance the model, leave the edge.
  task automatic step(input bit rst, input bit ld, input bit e);
    bit prev_all;
    reset    = ~rst;
    ifa.load = ld;
    ifb.load = ld;
    ifa.en   = e;
    ifb.en   = e;
    @(posedge clock);
    prev_all = (m_en_cnt >= m_need);
    m_rst    = rst;
    if (rst) begin
      m_done = 0; m_en_cnt = 0; m_need = 0; m_tgt1 = 0; m_tgt2 = 0;
    end else if (ld) begin
      m_done = 0; m_en_cnt = 0; m_need = pend_need; m_tgt1 = pend_t1; m_tgt2 = pend_t2;
    end else begin
      m_done = prev_all;
      if (e) m_en_cnt++;
    end
    m_done_cnt = m_done ? m_done_cnt + 1 : 0;
    m_valid    = 1'b1;
    #1;
  endtask

  task automatic clear_ranges();
    for (int i = 0; i < N; i++) begin
      r_s[i] = 1;
      r_e[i] = 0;
    end
  endtask

  task automatic do_load();
    apply_ranges();
    step(0, 1, 0);
  endtask

  task automatic run_to_settle(input string name, input int en_pct);
    int c = 0;
    while (m_done_cnt < S + 4 && c < 3000) begin
      step(0, 0, $urandom_range(99) < en_pct);
      c++;
    end
    if (m_done_cnt < S + 4) check({name, "_settle_timeout"}, 0, 1);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (m_valid) begin
      check("done_p1", ifa.done, m_done);
      check("done_p2", ifb.done, m_done);
      if (m_rst) begin
        check("rst_sum_p1", ifa.id_sum, 0);
        check("rst_sum_p2", ifb.id_sum, 0);
      end
      if (m_done_cnt >= S + 2) begin
        check("sum_p1", ifa.id_sum, m_tgt1);
        check("sum_p2", ifb.id_sum, m_tgt2);
      end
    end
  end

  initial begin
    int c;
    m_en_cnt = 0; m_need = 0; m_done_cnt = 0; m_tgt1 = 0; m_tgt2 = 0;
    m_rst = 0; m_done = 0;
    ifa.load = 0; ifb.load = 0; ifa.en = 0; ifb.en = 0;
    clear_ranges();
    apply_ranges();

    // model pins
    check("model_11_22_p1",    range_sum(11, 22, 1), 33);
    check("model_95_115_p2",   range_sum(95, 115, 2), 210);
    check("model_998_1012_p1", range_sum(998, 1012, 1), 1010);
    check("model_998_1012_p2", range_sum(998, 1012, 2), 2009);
    check("model_121212_p1",   64'(is_invalid(121212, 1)), 0);
    check("model_121212_p2",   64'(is_invalid(121212, 2)), 1);
    check("model_zero",        64'(is_invalid(0, 2)), 0);

    repeat (3) step(1, 0, 0);
    check("reset_done", ifa.done, 0);
    check("reset_sum",  ifa.id_sum, 0);

    clear_ranges(); r_s[0] = 11; r_e[0] = 22;
    do_load(); run_to_settle("r11_22", 100);
    check("p1_11_22", ifa.id_sum, 33);
    check("p1_11_22_done", ifa.done, 1);

    clear_ranges(); r_s[0] = 95; r_e[0] = 115;
    do_load(); run_to_settle("r95_115", 100);
    check("p1_95_115", ifa.id_sum, 99);
    check("p2_95_115", ifb.id_sum, 210);

    clear_ranges(); r_s[0] = 998; r_e[0] = 1012;
    do_load(); run_to_settle("r998_1012", 100);
    check("p1_998_1012", ifa.id_sum, 1010);
    check("p2_998_1012", ifb.id_sum, 2009);

    clear_ranges();
    for (int i = 0; i < 11; i++) begin r_s[i] = ex_s[i]; r_e[i] = ex_e[i]; end
    do_load(); run_to_settle("example", 100);
    check("p1_example", ifa.id_sum, 1227775554);
    check("p2_example", ifb.id_sum, 64'd4174379265);

    // start > end: done after W conversion cycles plus the done register
    clear_ranges(); r_s[0] = 50; r_e[0] = 40;
    do_load();
    c = 0;
    do begin step(0, 0, 1); c++; end while (!ifa.done && c < W + 20);
    check("empty_done_latency", c, W + 1);
    run_to_settle("empty", 100);
    check("empty_sum", ifa.id_sum, 0);

    // reset during SCAN, then reload
    clear_ranges();
    for (int i = 0; i < 11; i++) begin r_s[i] = ex_s[i]; r_e[i] = ex_e[i]; end
    do_load();
    repeat (W + 3) step(0, 0, 1);
    step(1, 0, 0);
    check("midrst_sum",  ifa.id_sum, 0);
    check("midrst_done", ifa.done, 0);
    step(0, 0, 0);
    clear_ranges(); r_s[0] = 11; r_e[0] = 22;
    do_load(); run_to_settle("reload", 100);
    check("reload_11_22", ifa.id_sum, 33);

    // randomized ranges, random en, and a double load where the second wins
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < N; i++) begin
        int mode = $urandom_range(2);
        if (mode == 0) begin
          r_s[i] = $urandom_range(999999);
          r_e[i] = r_s[i] + $urandom_range(20);
        end else if (mode == 1) begin
          int k = $urandom_range(4, 1);
          int r = $urandom_range(14 / k, 2);
          longint unsigned pk = 1, v = 0, blk;
          for (int j = 0; j < k; j++) pk *= 10;
          blk = $urandom_range(int'(pk - 1), int'(pk / 10));
          for (int j = 0; j < r; j++) v = v * pk + blk;
          r_s[i] = v - $urandom_range(10);
          r_e[i] = r_s[i] + $urandom_range(20);
        end else begin
          r_s[i] = $urandom_range(5000, 100);
          r_e[i] = r_s[i] - $urandom_range(50, 1);
        end
      end
      if (it % 2 == 1) begin
        apply_ranges();
        step(0, 1, 1);
        for (int i = 0; i < N; i++) r_e[i] = r_e[i] + 3;
      end
      do_load();
      run_to_settle("random", 70);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
